wb_mc_arbiter: RTL

//  Parametrised N-master Wishbone arbiter in front of the memory controller slave port (mc_top wb_*).

---
 rtl/wb_mc_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wb_mc_arbiter.sv
// wb_mc_arbiter: N-master Wishbone arbiter in front of the memory controller
// slave port. One master owns the bus for a whole cyc tenure. A watchdog
// terminates cycles that the slave never acknowledges.
module wb_mc_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int TIMEOUT     = 255,
    parameter int PRIO_MODE   = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_addr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_data_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    output logic [DW-1:0]               m_data_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [AW-1:0]               s_addr_o,
    output logic [DW-1:0]               s_data_o,
    output logic [DW/8-1:0]             s_sel_o,
    input  logic [DW-1:0]               s_data_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    output logic [NUM_MASTERS-1:0]      gnt_o,
    output logic                        timeout_o
);

    localparam int SW = DW / 8;
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DRAIN
    } state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic [IW-1:0]          gidx_q;
    logic [IW-1:0]          rr_ptr_q;
    logic [WW-1:0]          wdog_q;

    logic [IW-1:0] win_idx;
    logic          win_found;
    int            cand;
    logic [IW-1:0] cand_idx;

    logic          busy;
    logic          g_cyc;
    logic          g_stb;
    logic          stall;
    logic          wdog_full;
    logic          fire;
    logic [IW-1:0] next_ptr;

    // Winner search: rotate from rr_ptr in round-robin mode, from 0 in fixed-priority mode.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = (PRIO_MODE != 0) ? i : int'(rr_ptr_q) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            cand_idx = IW'(cand);
            if (!win_found && m_cyc_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Granted master's request view and the watchdog trip condition.
    always_comb begin
        busy      = (state_q == ST_BUSY);
        g_cyc     = m_cyc_i[gidx_q];
        g_stb     = g_cyc & m_stb_i[gidx_q];
        stall     = busy & g_stb & ~s_ack_i & ~s_err_i;
        wdog_full = (TIMEOUT > 0) && (wdog_q == WW'(TIMEOUT));
        fire      = stall & wdog_full;
        next_ptr  = (gidx_q == IW'(NUM_MASTERS - 1)) ? '0 : gidx_q + 1'b1;
    end

    // Slave-side mux: only a BUSY tenure drives the slave; the trip cycle drops cyc/stb.
    always_comb begin
        s_cyc_o   = busy & g_cyc & ~fire;
        s_stb_o   = busy & g_stb & ~fire;
        s_we_o    = busy & m_we_i[gidx_q];
        s_addr_o  = busy ? m_addr_i[gidx_q*AW +: AW] : '0;
        s_data_o  = busy ? m_data_i[gidx_q*DW +: DW] : '0;
        s_sel_o   = busy ? m_sel_i[gidx_q*SW +: SW] : '0;
        m_data_o  = busy ? s_data_i : '0;
        timeout_o = fire;
    end

    // Slave responses reach only the granted master; DRAIN swallows them.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
            assign m_ack_o[gi] = busy & gnt_q[gi] & s_ack_i;
            assign m_err_o[gi] = busy & gnt_q[gi] & (s_err_i | fire);
        end
    endgenerate

    assign gnt_o = gnt_q;

    // Arbitration FSM: grant, tenure tracking, watchdog count and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wdog_q <= '0;
                    if (win_found) begin
                        gnt_q   <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_idx;
                        gidx_q  <= win_idx;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!g_cyc) begin
                        state_q  <= ST_IDLE;
                        gnt_q    <= '0;
                        rr_ptr_q <= next_ptr;
                        wdog_q   <= '0;
                    end else if (fire) begin
                        state_q <= ST_DRAIN;
                        wdog_q  <= '0;
                    end else if (stall && (TIMEOUT > 0)) begin
                        wdog_q <= wdog_q + 1'b1;
                    end else begin
                        wdog_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    wdog_q <= '0;
                    if (!g_cyc) begin
                        state_q  <= ST_IDLE;
                        gnt_q    <= '0;
                        rr_ptr_q <= next_ptr;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    wdog_q  <= '0;
                end
            endcase
        end
    end

endmodule
